// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART host-link arbiter: FSM state encoding and
// requester identifiers.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    localparam logic REQ_DISK    = 1'b0;
    localparam logic REQ_CONSOLE = 1'b1;

    localparam int TURN_CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: a lone request wins outright, a tie goes to the
// requester that did not own the link last.
module rr_pick2
    import uart_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    // NOTE: every output gets a default first so no path through the block
    // leaves a value held, which would otherwise infer a latch.
    always_comb begin
        valid  = req0 | req1;
        winner = REQ_DISK;
        if (req0 && req1)
            winner = ~last_owner;
        else if (req1)
            winner = REQ_CONSOLE;
    end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one UART byte device between the disk engine (requester 0) and the
// console channel (requester 1); grants are held per transaction with a gap.
module uart_port_arbiter
    import uart_arb_pkg::*;
#(
    parameter int TURN_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_enable,
    input  logic       r1_enable,
    input  logic       r0_we,
    input  logic       r1_we,
    input  logic [7:0] r0_data_out,
    input  logic [7:0] r1_data_out,
    output logic       r0_read_done,
    output logic       r1_read_done,
    output logic       r0_write_done,
    output logic       r1_write_done,
    output logic [7:0] r_data_in,
    output logic       r0_grant,
    output logic       r1_grant,
    output logic       dev_enable,
    output logic       dev_we,
    output logic [7:0] dev_data_out,
    input  logic       dev_read_done,
    input  logic       dev_write_done,
    input  logic [7:0] dev_data_in
);

    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN_CYCLES - 1);

    arb_state_t              state;
    arb_state_t              arb_state;
    logic                    last_owner;
    logic [TURN_CNT_W-1:0]   turn_cnt;
    logic                    pick_valid;
    logic                    pick_winner;

    rr_pick2 u_pick (
        .req0       (r0_enable),
        .req1       (r1_enable),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Where IDLE (or an expired TURN) goes this cycle.
    assign arb_state = !pick_valid               ? IDLE :
                       (pick_winner == REQ_DISK) ? OWN0 : OWN1;

    // NOTE: all state below updates with non-blocking assignments so every
    // register sees the values from before the edge, regardless of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= REQ_CONSOLE;
            turn_cnt   <= '0;
            r0_grant   <= 1'b0;
            r1_grant   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= arb_state;
                    r0_grant <= (arb_state == OWN0);
                    r1_grant <= (arb_state == OWN1);
                end
                OWN0: begin
                    if (!r0_enable) begin
                        state      <= TURN;
                        last_owner <= REQ_DISK;
                        turn_cnt   <= TURN_LOAD;
                        r0_grant   <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!r1_enable) begin
                        state      <= TURN;
                        last_owner <= REQ_CONSOLE;
                        turn_cnt   <= TURN_LOAD;
                        r1_grant   <= 1'b0;
                    end
                end
                default: begin
                    if (turn_cnt == '0) begin
                        state    <= arb_state;
                        r0_grant <= (arb_state == OWN0);
                        r1_grant <= (arb_state == OWN1);
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign r_data_in = dev_data_in;

    // Device mux and done routing; TURN still forwards a late final completion
    // to the requester that just released.
    always_comb begin
        dev_enable    = 1'b0;
        dev_we        = 1'b0;
        dev_data_out  = '0;
        r0_read_done  = 1'b0;
        r0_write_done = 1'b0;
        r1_read_done  = 1'b0;
        r1_write_done = 1'b0;
        case (state)
            OWN0: begin
                dev_enable    = r0_enable;
                dev_we        = r0_we;
                dev_data_out  = r0_data_out;
                r0_read_done  = dev_read_done;
                r0_write_done = dev_write_done;
            end
            OWN1: begin
                dev_enable    = r1_enable;
                dev_we        = r1_we;
                dev_data_out  = r1_data_out;
                r1_read_done  = dev_read_done;
                r1_write_done = dev_write_done;
            end
            TURN: begin
                if (last_owner == REQ_DISK) begin
                    r0_read_done  = dev_read_done;
                    r0_write_done = dev_write_done;
                end else begin
                    r1_read_done  = dev_read_done;
                    r1_write_done = dev_write_done;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Scoreboard bench: stimulus queues expected observable vectors, a monitor
// compares them whenever a grant changes or a done pulse is routed.
module tb_uart_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_enable, r1_enable, r0_we, r1_we;
    logic [7:0] r0_data_out, r1_data_out;
    logic       r0_read_done, r1_read_done, r0_write_done, r1_write_done;
    logic [7:0] r_data_in;
    logic       r0_grant, r1_grant;
    logic       dev_enable, dev_we;
    logic [7:0] dev_data_out;
    logic       dev_read_done, dev_write_done;
    logic [7:0] dev_data_in;

    int tests_run = 0;
    int tests_failed = 0;
    logic mon_en = 1'b0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    uart_port_arbiter #(.TURN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_enable(r0_enable), .r1_enable(r1_enable),
        .r0_we(r0_we), .r1_we(r1_we),
        .r0_data_out(r0_data_out), .r1_data_out(r1_data_out),
        .r0_read_done(r0_read_done), .r1_read_done(r1_read_done),
        .r0_write_done(r0_write_done), .r1_write_done(r1_write_done),
        .r_data_in(r_data_in),
        .r0_grant(r0_grant), .r1_grant(r1_grant),
        .dev_enable(dev_enable), .dev_we(dev_we), .dev_data_out(dev_data_out),
        .dev_read_done(dev_read_done), .dev_write_done(dev_write_done),
        .dev_data_in(dev_data_in)
    );

    // {grants, dev_enable, dev_we, dev_data_out, r0 rd/wr done, r1 rd/wr done}
    logic [15:0] obs;
    assign obs = {r0_grant, r1_grant, dev_enable, dev_we, dev_data_out,
                  r0_read_done, r0_write_done, r1_read_done, r1_write_done};

    function automatic logic [15:0] mk(logic g0, logic g1, logic en, logic we,
                                       logic [7:0] d, logic [3:0] dn);
        return {g0, g1, en, we, d, dn};
    endfunction

    task automatic check(string name, logic [15:0] actual, logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_ev(string name, logic [15:0] v);
        name_q.push_back(name);
        exp_q.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_check(string name, logic [15:0] expected);
        @(negedge clk);
        check(name, obs, expected);
    endtask

    // Monitor: an event is a grant change or any routed done pulse.
    initial begin
        logic [1:0] prev_g;
        prev_g = 2'b00;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (obs[15:14] !== prev_g || obs[3:0] !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected event: got %h expected none", obs);
                end else begin
                    check(name_q.pop_front(), obs, exp_q.pop_front());
                end
            end
            prev_g = obs[15:14];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        r0_enable = 1'b0; r1_enable = 1'b0;
        r0_we = 1'b1; r1_we = 1'b1;
        r0_data_out = 8'hA5; r1_data_out = 8'h22;
        dev_read_done = 1'b0; dev_write_done = 1'b0; dev_data_in = 8'h00;

        // Reset state
        step(); step();
        mon_en = 1'b1;
        sample_check("reset outputs", 16'h0000);

        // Single write transaction on the disk requester
        step();
        rst_n = 1'b1;
        r0_enable = 1'b1;
        expect_ev("t1 grant0", mk(1, 0, 1, 1, 8'hA5, 4'b0000));
        step(); step();
        expect_ev("t1 write_done to r0", mk(1, 0, 1, 1, 8'hA5, 4'b0100));
        dev_write_done = 1'b1;
        step();
        dev_write_done = 1'b0;
        r0_enable = 1'b0;
        expect_ev("t1 release0", mk(0, 0, 0, 0, 8'h00, 4'b0000));
        step(); step(); step(); step();

        // Simultaneous requests straight out of reset: disk wins, gap of 2
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        r0_we = 1'b0; r0_data_out = 8'h11;
        r0_enable = 1'b1; r1_enable = 1'b1;
        expect_ev("t2 grant0 first", mk(1, 0, 1, 0, 8'h11, 4'b0000));
        step(); step();
        r0_enable = 1'b0;
        expect_ev("t2 release0", mk(0, 0, 0, 0, 8'h00, 4'b0000));
        expect_ev("t2 grant1", mk(0, 1, 1, 1, 8'h22, 4'b0000));
        step();
        sample_check("t2 gap cycle 1", 16'h0000);
        step();
        sample_check("t2 gap cycle 2", 16'h0000);
        step();
        sample_check("t2 grant1 latency", mk(0, 1, 1, 1, 8'h22, 4'b0000));

        // Console owns while disk waits; read completion goes to console only
        step();
        r0_enable = 1'b1;
        step();
        expect_ev("t3 read_done to r1", mk(0, 1, 1, 1, 8'h22, 4'b0010));
        dev_read_done = 1'b1;
        dev_data_in = 8'h3C;
        @(negedge clk);
        check("t3 r_data_in", {8'h00, r_data_in}, 16'h003C);
        step();
        dev_read_done = 1'b0;
        sample_check("t3 r0 waits", mk(0, 1, 1, 1, 8'h22, 4'b0000));

        // Late completion in the first TURN cycle goes to the releasing owner
        step();
        r1_enable = 1'b0;
        expect_ev("t4 release1 late done", mk(0, 0, 0, 0, 8'h00, 4'b0010));
        step();
        dev_read_done = 1'b1;
        step();
        dev_read_done = 1'b0;
        expect_ev("t4 grant0 after gap", mk(1, 0, 1, 0, 8'h11, 4'b0000));
        step(); step(); step();
        r0_enable = 1'b0;
        expect_ev("t4 release0", mk(0, 0, 0, 0, 8'h00, 4'b0000));
        step(); step(); step(); step(); step();
        dev_read_done = 1'b1;
        dev_write_done = 1'b1;
        sample_check("t4 idle drops done", 16'h0000);
        step();
        dev_read_done = 1'b0;
        dev_write_done = 1'b0;

        // Reset in the middle of an OWN0 transfer, then a tie goes to disk
        r0_enable = 1'b1;
        expect_ev("t5 grant0", mk(1, 0, 1, 0, 8'h11, 4'b0000));
        step(); step();
        rst_n = 1'b0;
        r1_enable = 1'b1;
        expect_ev("t5 reset drops grant", 16'h0000);
        step();
        sample_check("t5 reset state", 16'h0000);
        step();
        rst_n = 1'b1;
        expect_ev("t5 tie grants r0", mk(1, 0, 1, 0, 8'h11, 4'b0000));
        step(); step();

        // Back-to-back alternation: grants go 0 (above), 1, 0, 1, 0, 1
        begin
            logic owner;
            owner = 1'b0;
            for (int i = 1; i < 6; i++) begin
                if (owner == 1'b0) r0_enable = 1'b0;
                else               r1_enable = 1'b0;
                expect_ev($sformatf("t6 release %0d", i), 16'h0000);
                if (owner == 1'b0)
                    expect_ev($sformatf("t6 grant %0d", i), mk(0, 1, 1, 1, 8'h22, 4'b0000));
                else
                    expect_ev($sformatf("t6 grant %0d", i), mk(1, 0, 1, 0, 8'h11, 4'b0000));
                step();
                if (owner == 1'b0) r0_enable = 1'b1;
                else               r1_enable = 1'b1;
                step(); step(); step(); step();
                owner = ~owner;
            end
        end

        // Final release (console owns after the loop) and drain check
        r0_enable = 1'b0;
        r1_enable = 1'b0;
        expect_ev("final release", 16'h0000);
        step(); step(); step(); step(); step(); step();
        check("scoreboard drained", 16'(exp_q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_port_arbiter.md
# uart_port_arbiter

Shares the single byte-serial host link (the UART byte device carrying disk sector traffic) between two requesters: the disk device engine (requester 0) and the console/debug byte channel (requester 1). Grants are round-robin and held for the whole transaction, so a multi-byte disk exchange is never interleaved with console bytes. A short turnaround gap separates owners. Sits between the requesters and the UART byte device; each requester sees an interface identical to a private device.

## Interface
Parameters:
- TURN_CYCLES, 2: idle cycles with dev_enable forced low between owner release and next grant (legal 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- r0_enable, r1_enable  in  1 each  requester holds high for entire transaction
- r0_we, r1_we  in  1 each  requester byte direction (1 = send)
- r0_data_out, r1_data_out  in  8 each  byte to send
- r0_read_done, r1_read_done  out  1 each  routed dev_read_done
- r0_write_done, r1_write_done  out  1 each  routed dev_write_done
- r_data_in  out  8  dev_data_in broadcast to both requesters
- r0_grant, r1_grant  out  1 each  registered ownership indication
- dev_enable  out  1  to byte device
- dev_we  out  1  to byte device
- dev_data_out  out  8  to byte device
- dev_read_done, dev_write_done  in  1 each  byte completion pulses
- dev_data_in  in  8  received byte

## Operation
- States: IDLE, OWN0, OWN1, TURN.
- IDLE: if exactly one rN_enable high -> OWNN. Both high -> requester other than last_owner wins; last_owner resets to 1 (disk wins first tie after reset).
- OWNN: dev_enable/dev_we/dev_data_out = rN_enable/rN_we/rN_data_out (combinational mux on registered state). rN_enable low -> TURN, last_owner <= N, turn counter <= TURN_CYCLES-1.
- TURN: dev_enable=0, dev_we=0, dev_data_out=0; counter decrements; at 0 -> arbitrate exactly as IDLE (straight to OWNx if request present, else IDLE).
- Done routing: in OWNN, dev_*_done goes to rN only. In TURN, done pulses go to last_owner (late completion of a final byte). In IDLE, done pulses are dropped. Non-routed done outputs are 0.
- r_data_in = dev_data_in always (unregistered).
- Requester deasserting then reasserting enable within one cycle still passes through TURN; no re-grant without gap.
- No preemption: an owner holds grant indefinitely while enable high.

## Timing
- Reset (rst_n low at a clk edge): state IDLE, last_owner 1, counter 0, r0_grant=r1_grant=0, dev_enable=0, dev_we=0, dev_data_out=0, all rN_*_done=0. Reset mid-transaction drops the grant immediately; no drain.
- Grant latency: rN_enable sampled high at edge k (state IDLE) -> OWNN and rN_grant=1 after edge k; dev_enable high in cycle k+1.
- Release: rN_enable low sampled at edge k -> TURN after edge k; dev_enable low from cycle k+1 for TURN_CYCLES cycles; next owner drives dev_enable at cycle k+1+TURN_CYCLES earliest.
- Done routing is combinational, zero added latency.
- Counter width 4 bits; no wrap, stops at 0.

## Structure
- Package uart_arb_pkg: state encoding (2-bit localparams IDLE=0, OWN0=1, OWN1=2, TURN=3), requester id constants REQ_DISK=0, REQ_CONSOLE=1.
- One sub-module natural: rr_pick2 (combinational 2-way round-robin choice from two requests plus last_owner, outputs valid and winner id).
- Remainder (FSM, turn counter, muxes) in uart_port_arbiter.

## Test plan
- Reset, then r0_enable=1, r0_we=1, r0_data_out=8'hA5 -> after one edge r0_grant=1, dev_enable=1, dev_data_out=8'hA5; dev_write_done pulse appears only on r0_write_done.
- r0 and r1 enable asserted same cycle from reset -> r0 granted first; r1 granted exactly TURN_CYCLES+1 edges after r0_enable drops; dev_enable low for exactly 2 cycles between.
- r1 owns, r0 requests throughout -> r0 waits with r0_grant=0, r0 done outputs stay 0 while dev_read_done pulses for r1 with dev_data_in=8'h3C.
- Owner drops enable, dev_read_done pulses in first TURN cycle -> pulse delivered to that requester only; pulse in IDLE -> both done outputs 0.
- rst_n low during OWN0 mid-transfer -> next cycle dev_enable=0, both grants 0, state IDLE; subsequent simultaneous requests grant r0.
- Back-to-back alternating: both requesters reassert immediately after each release for 6 transactions -> grants alternate 0,1,0,1,0,1.
